// File: rtl/xor_accum_pkg.sv
// Shared types and helpers for the streaming XOR/parity frame accumulator.
package xor_accum_pkg;

   // Control states: collecting words, or holding a finished result.
   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Width of a counter able to hold 0..max_words inclusive.
   function automatic int cw_f(input int max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/nor_xor2.sv
// Two-input XOR built only from NOR primitives (five gates).
module nor_xor2 (
   output logic s,
   input  logic a,
   input  logic b
);

   logic n_ab;    // ~(a|b)
   logic n_a;     // ~a & b
   logic n_b;     // a & ~b
   logic xn;      // xnor(a,b)

   nor g0 (n_ab, a, b);
   nor g1 (n_a, a, n_ab);
   nor g2 (n_b, b, n_ab);
   nor g3 (xn, n_a, n_b);
   nor g4 (s, xn, xn);

endmodule

// File: rtl/xor_frame_accum.sv
// Streaming accumulator: folds a frame of words into one XOR word plus parity.
// Datapath is NOR-based XOR cells; control is a two-state handshake FSM.
module xor_frame_accum
   import xor_accum_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_WORDS = 4,
   parameter int ODD       = 0,
   localparam int CW       = cw_f(MAX_WORDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic             out_err
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ov_q, ov_d;
   logic [WIDTH-1:0] ox_q, ox_d;
   logic             op_q, op_d;
   logic [CW-1:0]    oc_q, oc_d;
   logic             oe_q, oe_d;

   logic [WIDTH-1:0] nx;       // acc ^ in_data
   logic [WIDTH-1:0] par_c;    // running parity chain over nx
   logic             par_w;    // final parity incl. ODD
   logic             odd_b;
   logic [CW-1:0]    cnt_inc;

   assign odd_b   = (ODD != 0);
   assign cnt_inc = count_q + CW'(1);

   // Per-bit accumulator update
   for (genvar i = 0; i < WIDTH; i++) begin : g_acc
      nor_xor2 u_acc (.s(nx[i]), .a(acc_q[i]), .b(in_data[i]));
   end

   // Parity: fold nx down to one bit, then apply the odd/even selector
   assign par_c[0] = nx[0];
   for (genvar i = 1; i < WIDTH; i++) begin : g_par
      nor_xor2 u_par (.s(par_c[i]), .a(par_c[i-1]), .b(nx[i]));
   end
   nor_xor2 u_odd (.s(par_w), .a(par_c[WIDTH-1]), .b(odd_b));

   assign in_ready   = (state_q == ST_ACC);
   assign out_valid  = ov_q;
   assign out_xor    = ox_q;
   assign out_parity = op_q;
   assign out_count  = oc_q;
   assign out_err    = oe_q;

   // Next-state logic: clear beats everything, then accept/close or result handshake
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ov_d    = ov_q;
      ox_d    = ox_q;
      op_d    = op_q;
      oc_d    = oc_q;
      oe_d    = oe_q;
      if (clear) begin
         state_d = ST_ACC;
         acc_d   = '0;
         count_d = '0;
         ov_d    = 1'b0;
         ox_d    = '0;
         op_d    = 1'b0;
         oc_d    = '0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (in_valid) begin
                  if (in_last || (cnt_inc == CW'(MAX_WORDS))) begin
                     // Close: publish result, restart accumulation
                     ox_d    = nx;
                     op_d    = par_w;
                     oc_d    = cnt_inc;
                     oe_d    = ~in_last;
                     ov_d    = 1'b1;
                     acc_d   = '0;
                     count_d = '0;
                     state_d = ST_HOLD;
                  end else begin
                     acc_d   = nx;
                     count_d = cnt_inc;
                  end
               end
            end
            ST_HOLD: begin
               // Result stays stable until taken; no accept this cycle
               if (out_ready) begin
                  ov_d    = 1'b0;
                  state_d = ST_ACC;
               end
            end
            default: state_d = ST_ACC;
         endcase
      end
   end

   // State and output registers, async active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         count_q <= '0;
         ov_q    <= 1'b0;
         ox_q    <= '0;
         op_q    <= 1'b0;
         oc_q    <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ov_q    <= ov_d;
         ox_q    <= ox_d;
         op_q    <= op_d;
         oc_q    <= oc_d;
         oe_q    <= oe_d;
      end
   end

endmodule

// File: tb/tb_xor_frame_accum.sv
// Directed bench: two instances (even and odd parity) driven by one input stream.
module tb_xor_frame_accum;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;

   logic       in_ready0, out_valid0, out_parity0, out_err0;
   logic [3:0] out_xor0;
   logic [2:0] out_count0;
   logic       in_ready1, out_valid1, out_parity1, out_err1;
   logic [3:0] out_xor1;
   logic [2:0] out_count1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xor_frame_accum #(.WIDTH(4), .MAX_WORDS(4), .ODD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready), .out_xor(out_xor0),
      .out_parity(out_parity0), .out_count(out_count0), .out_err(out_err0)
   );

   xor_frame_accum #(.WIDTH(4), .MAX_WORDS(4), .ODD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid1), .out_ready(out_ready), .out_xor(out_xor1),
      .out_parity(out_parity1), .out_count(out_count1), .out_err(out_err1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic word(input logic [3:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic result(input string tag, input logic [3:0] x, input logic p,
                         input logic [2:0] c, input logic e);
      chk({tag, "_valid"}, out_valid0, 1'b1);
      chk({tag, "_xor"},   out_xor0,   x);
      chk({tag, "_par"},   out_parity0, p);
      chk({tag, "_cnt"},   out_count0, c);
      chk({tag, "_err"},   out_err0,   e);
      chk({tag, "_rdy"},   in_ready0,  1'b0);
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      // 1: reset, then reset again mid-frame
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", in_ready0, 1'b1);
      chk("rst_valid", out_valid0, 1'b0);
      word(4'b0011, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid", out_valid0, 1'b0);
      chk("rstmid_xor",   out_xor0, 4'h0);
      chk("rstmid_cnt",   out_count0, 3'd0);
      chk("rstmid_err",   out_err0, 1'b0);
      chk("rstmid_par",   out_parity0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel_ready", in_ready0, 1'b1);

      // 2: three-word frame; partial frame from before reset must be gone
      word(4'b0011, 1'b0);
      word(4'b0101, 1'b0);
      chk("f2_notyet", out_valid0, 1'b0);
      word(4'b1111, 1'b1);
      result("f2", 4'b1001, 1'b0, 3'd3, 1'b0);
      chk("f2_oddpar", out_parity1, 1'b1);

      // 3: backpressure with a word waiting
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ready", in_ready0, 1'b0);
         chk("bp_valid", out_valid0, 1'b1);
         chk("bp_xor",   out_xor0, 4'b1001);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_drop",  out_valid0, 1'b0);
      chk("bp_rdy",   in_ready0, 1'b1);
      chk("bp_keep",  out_xor0, 4'b1001);
      tick();                      // 1010 accepted here
      word(4'b0101, 1'b1);
      result("f3", 4'b1111, 1'b0, 3'd2, 1'b0);
      take();
      chk("f3_keep", out_xor0, 4'b1111);

      // 4: overflow close without last
      out_ready = 1'b1;            // no effect while nothing is pending
      word(4'b0001, 1'b0);
      out_ready = 1'b0;
      word(4'b0010, 1'b0);
      word(4'b0100, 1'b0);
      chk("ov_notyet", out_valid0, 1'b0);
      word(4'b1000, 1'b0);
      result("ov", 4'b1111, 1'b0, 3'd4, 1'b1);
      take();

      // last and MAX_WORDS coincide: normal close
      word(4'b0001, 1'b0);
      word(4'b0001, 1'b0);
      word(4'b0011, 1'b0);
      word(4'b0100, 1'b1);
      result("lm", 4'b0111, 1'b1, 3'd4, 1'b0);
      chk("lm_oddpar", out_parity1, 1'b0);
      take();

      // 5: single-word frame on the odd-parity instance
      word(4'b0001, 1'b1);
      chk("odd_valid", out_valid1, 1'b1);
      chk("odd_xor",   out_xor1, 4'b0001);
      chk("odd_par",   out_parity1, 1'b0);
      chk("odd_cnt",   out_count1, 3'd1);
      chk("odd_err",   out_err1, 1'b0);
      chk("even_par",  out_parity0, 1'b1);
      take();

      // 6: clear mid-frame drops partial data and the presented word
      word(4'b1111, 1'b0);
      word(4'b0001, 1'b0);
      clear = 1'b1;
      word(4'b1000, 1'b1);
      clear = 1'b0;
      chk("clr_valid", out_valid0, 1'b0);
      chk("clr_xor",   out_xor0, 4'h0);
      word(4'b0110, 1'b1);
      result("clr", 4'b0110, 1'b0, 3'd1, 1'b0);

      // clear while holding a result
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clrh_valid", out_valid0, 1'b0);
      chk("clrh_xor",   out_xor0, 4'h0);
      chk("clrh_cnt",   out_count0, 3'd0);
      chk("clrh_rdy",   in_ready0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
